// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side signal bundle for mult_arbiter.
// slave = arbiter view, master = surrounding requesters plus multiplier.
interface mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] op_a;
    logic [NUM_REQ*DATA_W-1:0] op_b;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        resp_valid;
    logic                      resp_err;
    logic [2*DATA_W-1:0]       result;
    logic                      busy;
    logic                      mult_start;
    logic [DATA_W-1:0]         mult_dataa;
    logic [DATA_W-1:0]         mult_datab;
    logic                      mult_done;
    logic [2*DATA_W-1:0]       mult_product;

    modport slave (
        input  req, op_a, op_b, mult_done, mult_product,
        output gnt, resp_valid, resp_err, result, busy,
               mult_start, mult_dataa, mult_datab
    );

    modport master (
        output req, op_a, op_b, mult_done, mult_product,
        input  gnt, resp_valid, resp_err, result, busy,
               mult_start, mult_dataa, mult_datab
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one start/done multiplier among NUM_REQ requesters.
// Optional WAIT watchdog is enabled with `define MULT_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no job; arbitrate among req from rr_ptr, capture winner operands
// START | one-cycle mult_start to the multiplier
// WAIT  | wait for mult_done (or watchdog expiry when enabled)
// RESP  | one-cycle resp_valid to winner, advance rr_ptr, drop gnt
module mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mult_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    winner;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                resp_err_q;
    logic [2*DATA_W-1:0] result_q;
    logic [DATA_W-1:0]   dataa_q;
    logic [DATA_W-1:0]   datab_q;

    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    cand;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    // Down-counter loaded in START; reaching zero in WAIT marks the last allowed cycle.
    logic [TMR_W-1:0] tmr;
    logic             tmr_tc;
    assign tmr_tc = (tmr == '0);
`endif

    // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                sel_a = bus.op_a[k*DATA_W +: DATA_W];
                sel_b = bus.op_b[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (found) state_nxt = START;
            START: state_nxt = WAIT;
            WAIT: begin
                if (bus.mult_done) begin
                    state_nxt = RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (tmr_tc) begin
                    state_nxt = RESP;
                end
`endif
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            winner     <= '0;
            gnt_q      <= '0;
            resp_err_q <= 1'b0;
            result_q   <= '0;
            dataa_q    <= '0;
            datab_q    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            tmr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner  <= pick;
                        gnt_q   <= NUM_REQ'(1) << pick;
                        dataa_q <= sel_a;
                        datab_q <= sel_b;
                    end
                end
                START: begin
`ifdef MULT_ARB_TIMEOUT_EN
                    tmr <= TMR_W'(TIMEOUT_CYC - 1);
`endif
                end
                WAIT: begin
                    // A done arriving on the expiry cycle takes priority over the abort.
                    if (bus.mult_done) begin
                        result_q   <= bus.mult_product;
                        resp_err_q <= 1'b0;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (tmr_tc) begin
                        result_q   <= '0;
                        resp_err_q <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    gnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.resp_valid = (state == RESP) ? gnt_q : '0;
    assign bus.resp_err   = resp_err_q;
    assign bus.result     = result_q;
    assign bus.busy       = (state != IDLE);
    assign bus.mult_start = (state == START);
    assign bus.mult_dataa = dataa_q;
    assign bus.mult_datab = datab_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a 4-cycle behavioural multiplier model.
// Timeout scenario adapts to whether MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mult_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    mult_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          model_en = 1'b0;
    int          m_cnt    = 0;
    logic [15:0] m_prod   = '0;

    // Multiplier model acts at posedge+2 so it never races the test's posedge+1 sampling.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!model_en || reset) begin
                m_cnt = 0;
            end else begin
                bus.mult_done = 1'b0;
                if (m_cnt != 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        bus.mult_done    = 1'b1;
                        bus.mult_product = m_prod;
                    end
                end
                if (bus.mult_start) begin
                    m_cnt  = 4;
                    m_prod = 16'(bus.mult_dataa) * 16'(bus.mult_datab);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset         = 1'b1;
        bus.req       = '0;
        bus.mult_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.op_a[i*DW +: DW] = a;
        bus.op_b[i*DW +: DW] = b;
    endtask

    task automatic wait_resp(output logic [NR-1:0] rv, output bit ok);
        ok = 1'b0;
        rv = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (bus.resp_valid != '0) begin
                ok = 1'b1;
                rv = bus.resp_valid;
            end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({bus.gnt, bus.resp_valid, bus.busy, bus.mult_start, bus.resp_err} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got gnt=%b rv=%b busy=%b start=%b err=%b exp all 0",
                     bus.gnt, bus.resp_valid, bus.busy, bus.mult_start, bus.resp_err);
        end
        checks++;
        if ({bus.result, bus.mult_dataa, bus.mult_datab} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got result=%h a=%h b=%h exp 0",
                     bus.result, bus.mult_dataa, bus.mult_datab);
        end
    endtask

    task automatic test_single();
        logic [NR-1:0] rv;
        bit ok;
        reset_dut();
        model_en = 1'b1;
        set_ops(0, 8'h0F, 8'h11);
        bus.req = 4'b0001;
        tick();
        checks++;
        if (bus.mult_start !== 1'b1 || bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_start got start=%b gnt=%b busy=%b exp 1/0001/1",
                     bus.mult_start, bus.gnt, bus.busy);
        end
        checks++;
        if (bus.mult_dataa !== 8'h0F || bus.mult_datab !== 8'h11) begin
            failures++;
            $display("FAIL single_operands got a=%h b=%h exp 0f/11", bus.mult_dataa, bus.mult_datab);
        end
        tick();
        checks++;
        if (bus.mult_start !== 1'b0) begin
            failures++;
            $display("FAIL single_start_pulse got start=%b in WAIT exp 0", bus.mult_start);
        end
        wait_resp(rv, ok);
        bus.req = '0;
        checks++;
        if (!ok || rv !== 4'b0001 || bus.result !== 16'h00FF || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_resp got ok=%0d rv=%b result=%h err=%b exp 1/0001/00ff/0",
                     ok, rv, bus.result, bus.resp_err);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.resp_valid !== '0) begin
            failures++;
            $display("FAIL single_idle got busy=%b gnt=%b rv=%b exp 0", bus.busy, bus.gnt, bus.resp_valid);
        end
    endtask

    task automatic test_contention();
        logic [NR-1:0] rv;
        logic [NR-1:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        logic [15:0]   exp_r [6] = '{16'd6, 16'd12, 16'd30, 16'd6, 16'd12, 16'd30};
        bit ok;
        bit got_g;
        reset_dut();
        model_en = 1'b1;
        set_ops(0, 8'd2, 8'd3);
        set_ops(1, 8'd3, 8'd4);
        set_ops(2, 8'd4, 8'd5);
        set_ops(3, 8'd5, 8'd6);
        bus.req = 4'b1011;
        for (int j = 0; j < 6; j++) begin
            got_g = 1'b0;
            for (int c = 0; c < 10 && !got_g; c++) begin
                tick();
                got_g = (bus.gnt != '0);
            end
            checks++;
            if (!got_g || bus.gnt !== exp_g[j]) begin
                failures++;
                $display("FAIL contention_gnt job=%0d got gnt=%b exp %b", j, bus.gnt, exp_g[j]);
            end
            wait_resp(rv, ok);
            checks++;
            if (!ok || rv !== exp_g[j] || bus.result !== exp_r[j]) begin
                failures++;
                $display("FAIL contention_resp job=%0d got rv=%b result=%h exp %b/%h",
                         j, rv, bus.result, exp_g[j], exp_r[j]);
            end
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_late_drop();
        logic [NR-1:0] rv;
        bit ok;
        reset_dut();
        model_en = 1'b1;
        set_ops(2, 8'hFF, 8'hFF);
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL late_drop_gnt got gnt=%b exp 0100", bus.gnt);
        end
        tick();
        bus.req = '0;
        set_ops(2, 8'h01, 8'h02);
        tick();
        checks++;
        if (bus.mult_dataa !== 8'hFF || bus.mult_datab !== 8'hFF || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL late_drop_hold got a=%h b=%h busy=%b exp ff/ff/1",
                     bus.mult_dataa, bus.mult_datab, bus.busy);
        end
        wait_resp(rv, ok);
        checks++;
        if (!ok || rv !== 4'b0100 || bus.result !== 16'hFE01) begin
            failures++;
            $display("FAIL late_drop_resp got ok=%0d rv=%b result=%h exp 1/0100/fe01", ok, rv, bus.result);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] rv;
        bit ok;
        reset_dut();
        model_en = 1'b1;
        set_ops(2, 8'd2, 8'd5);
        bus.req = 4'b0100;
        wait_resp(rv, ok);
        bus.req = '0;
        checks++;
        if (!ok || rv !== 4'b0100 || bus.result !== 16'd10) begin
            failures++;
            $display("FAIL reset_mid_pre got rv=%b result=%h exp 0100/000a", rv, bus.result);
        end
        tick();
        model_en = 1'b0;
        set_ops(3, 8'd7, 8'd7);
        bus.req = 4'b1000;
        tick();
        tick();
        tick();
        reset   = 1'b1;
        bus.req = '0;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.gnt, bus.resp_valid, bus.busy, bus.mult_start, bus.mult_dataa, bus.result} !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear got gnt=%b rv=%b busy=%b start=%b a=%h result=%h exp 0",
                     bus.gnt, bus.resp_valid, bus.busy, bus.mult_start, bus.mult_dataa, bus.result);
        end
        bus.mult_done    = 1'b1;
        bus.mult_product = 16'hBEEF;
        tick();
        bus.mult_done = 1'b0;
        checks++;
        if (bus.resp_valid !== '0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_late_done got rv=%b busy=%b exp 0/0", bus.resp_valid, bus.busy);
        end
        model_en = 1'b1;
        set_ops(1, 8'd6, 8'd7);
        bus.req = 4'b1010;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL reset_mid_rrptr got gnt=%b exp 0010", bus.gnt);
        end
        wait_resp(rv, ok);
        bus.req = '0;
        checks++;
        if (!ok || rv !== 4'b0010 || bus.result !== 16'h002A) begin
            failures++;
            $display("FAIL reset_mid_next got rv=%b result=%h exp 0010/002a", rv, bus.result);
        end
        tick();
    endtask

    task automatic test_stray_done();
        reset_dut();
        model_en         = 1'b0;
        bus.mult_done    = 1'b1;
        bus.mult_product = 16'h5555;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== '0) begin
            failures++;
            $display("FAIL stray_idle got busy=%b rv=%b exp 0/0", bus.busy, bus.resp_valid);
        end
        set_ops(0, 8'h12, 8'h34);
        bus.req = 4'b0001;
        tick();
        checks++;
        if (bus.mult_start !== 1'b1 || bus.resp_valid !== '0) begin
            failures++;
            $display("FAIL stray_start got start=%b rv=%b exp 1/0", bus.mult_start, bus.resp_valid);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.resp_valid !== '0 || bus.mult_start !== 1'b0) begin
            failures++;
            $display("FAIL stray_in_start got busy=%b rv=%b start=%b exp 1/0/0",
                     bus.busy, bus.resp_valid, bus.mult_start);
        end
        bus.mult_done = 1'b0;
        tick();
        checks++;
        if (bus.resp_valid !== '0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL stray_wait got rv=%b busy=%b exp 0/1", bus.resp_valid, bus.busy);
        end
        bus.mult_done    = 1'b1;
        bus.mult_product = 16'h1234;
        tick();
        bus.mult_done = 1'b0;
        bus.req       = '0;
        checks++;
        if (bus.resp_valid !== 4'b0001 || bus.result !== 16'h1234) begin
            failures++;
            $display("FAIL stray_real_done got rv=%b result=%h exp 0001/1234", bus.resp_valid, bus.result);
        end
        tick();
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [NR-1:0] rv;
        bit ok;
        int n;
        reset_dut();
        model_en = 1'b1;
        set_ops(0, 8'd3, 8'd4);
        bus.req = 4'b0001;
        wait_resp(rv, ok);
        bus.req = '0;
        tick();
        model_en = 1'b0;
        set_ops(0, 8'd9, 8'd9);
        bus.req = 4'b0001;
        tick();
        n  = 0;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            tick();
            n++;
            ok = (bus.resp_valid != '0);
        end
        bus.req = '0;
        checks++;
        if (!ok || n != 17) begin
            failures++;
            $display("FAIL timeout_latency got ok=%0d cycles=%0d exp 1/17", ok, n);
        end
        checks++;
        if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b1 || bus.result !== 16'h0) begin
            failures++;
            $display("FAIL timeout_resp got rv=%b err=%b result=%h exp 0001/1/0000",
                     bus.resp_valid, bus.resp_err, bus.result);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_busy got busy=%b exp 0", bus.busy);
        end
        model_en = 1'b1;
        bus.req  = 4'b0001;
        wait_resp(rv, ok);
        bus.req = '0;
        checks++;
        if (!ok || rv !== 4'b0001 || bus.resp_err !== 1'b0 || bus.result !== 16'h0051) begin
            failures++;
            $display("FAIL timeout_recover got rv=%b err=%b result=%h exp 0001/0/0051",
                     rv, bus.resp_err, bus.result);
        end
        tick();
    endtask
`else
    task automatic test_timeout();
        bit seen;
        reset_dut();
        model_en = 1'b0;
        set_ops(0, 8'd9, 8'd9);
        bus.req = 4'b0001;
        seen    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.resp_valid != '0) seen = 1'b1;
        end
        checks++;
        if (seen || bus.busy !== 1'b1 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout_wait got seen=%0d busy=%b err=%b exp 0/1/0", seen, bus.busy, bus.resp_err);
        end
        bus.mult_done    = 1'b1;
        bus.mult_product = 16'h0051;
        tick();
        bus.mult_done = 1'b0;
        bus.req       = '0;
        checks++;
        if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b0 || bus.result !== 16'h0051) begin
            failures++;
            $display("FAIL no_timeout_resp got rv=%b err=%b result=%h exp 0001/0/0051",
                     bus.resp_valid, bus.resp_err, bus.result);
        end
        tick();
    endtask
`endif

    initial begin
        bus.req          = '0;
        bus.op_a         = '0;
        bus.op_b         = '0;
        bus.mult_done    = 1'b0;
        bus.mult_product = '0;
        test_reset();
        test_single();
        test_contention();
        test_late_drop();
        test_reset_mid();
        test_stray_done();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
